// File: rtl/cache_axi_bridge.sv
// Single-master AXI3 bridge for the instruction and data caches; one single-beat transaction at a time.
// Latency: a request pulse at edge N gives arvalid/awvalid from N+1; the fastest return pulse is in cycle N+3.
// Backpressure: each port holds one pending request; AXI valids hold with a stable payload until their handshake.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   i_inst_* / o_inst_*         fetch request (addr) and return (ready pulse, rdata)
//   i_data_* / o_data_*         data request (wen, r/w size, r/w addr, wdata) and return
//   o_ar* / i_arready           AXI read address channel
//   i_r* / o_rready             AXI read data channel (rid, rresp, rlast ignored)
//   o_aw* / i_awready           AXI write address channel
//   o_w* / i_wready             AXI write data channel
//   i_b* / o_bready             AXI write response channel (bid, bresp ignored)
module cache_axi_bridge #(
  parameter logic [3:0] DATA_ID = 4'd1,
  parameter logic [3:0] INST_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inst_call_begin,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_return_ready,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_call_begin,
  input  logic        i_data_wen,
  input  logic [2:0]  i_data_rsize,
  input  logic [2:0]  i_data_wsize,
  input  logic [31:0] i_data_raddr,
  input  logic [31:0] i_data_waddr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_return_ready,
  output logic [31:0] o_data_rdata,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic [1:0]  o_arlock,
  output logic [3:0]  o_arcache,
  output logic [2:0]  o_arprot,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [3:0]  i_rid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [3:0]  o_awid,
  output logic [31:0] o_awaddr,
  output logic [7:0]  o_awlen,
  output logic [2:0]  o_awsize,
  output logic [1:0]  o_awburst,
  output logic [1:0]  o_awlock,
  output logic [3:0]  o_awcache,
  output logic [2:0]  o_awprot,
  output logic        o_awvalid,
  input  logic        i_awready,
  output logic [3:0]  o_wid,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_wlast,
  output logic        o_wvalid,
  input  logic        i_wready,
  input  logic [3:0]  i_bid,
  input  logic [1:0]  i_bresp,
  input  logic        i_bvalid,
  output logic        o_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_owner_d;                // 1: data port owns the current transaction
  logic        r_aw_done, r_w_done;      // per-channel handshake completed in AW_W
  logic        r_pend_i, r_pend_d;
  logic [31:0] r_inst_addr;
  logic        r_d_wen;
  logic [2:0]  r_d_rsize, r_d_wsize;
  logic [31:0] r_d_raddr, r_d_waddr, r_d_wdata;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic        w_in_ar, w_in_aw_w, w_clr_i, w_clr_d;
  logic [3:0]  w_wstrb;
  logic        w_unused_ok;

  assign w_unused_ok = ^{i_rid, i_rresp, i_rlast, i_bid, i_bresp};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_pend_d)      w_next = r_d_wen ? S_AW_W : S_AR;
        else if (r_pend_i) w_next = S_AR;
      end
      S_AR:   if (i_arready) w_next = S_R;
      S_R:    if (i_rvalid)  w_next = S_RESP;
      S_AW_W: if ((r_aw_done | i_awready) & (r_w_done | i_wready)) w_next = S_B;
      S_B:    if (i_bvalid)  w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_in_ar   = (r_state == S_AR);
  assign w_in_aw_w = (r_state == S_AW_W);
  assign w_clr_i   = (r_state == S_RESP) & ~r_owner_d;
  assign w_clr_d   = (r_state == S_RESP) &  r_owner_d;

  // A pulse landing on the owner's own RESP edge is accepted as the next request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_i    <= 1'b0;
      r_inst_addr <= '0;
    end else if (i_inst_call_begin && (!r_pend_i || w_clr_i)) begin
      r_pend_i    <= 1'b1;
      r_inst_addr <= i_inst_addr;
    end else if (w_clr_i) begin
      r_pend_i    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_d  <= 1'b0;
      r_d_wen   <= 1'b0;
      r_d_rsize <= '0;
      r_d_wsize <= '0;
      r_d_raddr <= '0;
      r_d_waddr <= '0;
      r_d_wdata <= '0;
    end else if (i_data_call_begin && (!r_pend_d || w_clr_d)) begin
      r_pend_d  <= 1'b1;
      r_d_wen   <= i_data_wen;
      r_d_rsize <= i_data_rsize;
      r_d_wsize <= i_data_wsize;
      r_d_raddr <= i_data_raddr;
      r_d_waddr <= i_data_waddr;
      r_d_wdata <= i_data_wdata;
    end else if (w_clr_d) begin
      r_pend_d  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner_d    <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      // Data wins arbitration; the choice only matters on the IDLE cycle that leaves IDLE.
      if (r_state == S_IDLE) r_owner_d <= r_pend_d;
      if (w_in_aw_w) begin
        if (i_awready) r_aw_done <= 1'b1;
        if (i_wready)  r_w_done  <= 1'b1;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == S_R && i_rvalid) begin
        if (r_owner_d) r_data_rdata <= i_rdata;
        else           r_inst_rdata <= i_rdata;
      end
      if (r_state == S_B && i_bvalid) r_data_rdata <= '0;
    end
  end

  always_comb begin
    w_wstrb = 4'b1111;
    case (r_d_wsize)
      3'd0:    w_wstrb = 4'b0001 << r_d_waddr[1:0];
      3'd1:    w_wstrb = r_d_waddr[1] ? 4'b1100 : 4'b0011;
      default: w_wstrb = 4'b1111;
    endcase
  end

  // Payloads are forced to zero outside their valid phase so idle outputs read as 0.
  assign o_arvalid = w_in_ar;
  assign o_araddr  = w_in_ar ? (r_owner_d ? r_d_raddr : r_inst_addr) : '0;
  assign o_arsize  = w_in_ar ? (r_owner_d ? r_d_rsize : 3'd2) : '0;
  assign o_arid    = w_in_ar ? (r_owner_d ? DATA_ID : INST_ID) : '0;
  assign o_arlen   = 8'd0;
  assign o_arburst = 2'b01;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'b0000;
  assign o_arprot  = 3'b000;
  assign o_rready  = (r_state == S_R);

  assign o_awvalid = w_in_aw_w & ~r_aw_done;
  assign o_awaddr  = w_in_aw_w ? r_d_waddr : '0;
  assign o_awsize  = w_in_aw_w ? r_d_wsize : '0;
  assign o_awid    = DATA_ID;
  assign o_awlen   = 8'd0;
  assign o_awburst = 2'b01;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'b0000;
  assign o_awprot  = 3'b000;

  assign o_wvalid  = w_in_aw_w & ~r_w_done;
  assign o_wdata   = w_in_aw_w ? r_d_wdata : '0;
  assign o_wstrb   = w_in_aw_w ? w_wstrb : '0;
  assign o_wid     = DATA_ID;
  assign o_wlast   = 1'b1;
  assign o_bready  = (r_state == S_B);

  assign o_inst_return_ready = w_clr_i;
  assign o_data_return_ready = w_clr_d;
  assign o_inst_rdata        = r_inst_rdata;
  assign o_data_rdata        = r_data_rdata;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Testbench for cache_axi_bridge: transaction-level model plus directed scenarios and random traffic.
// Latency: inputs change 1 time unit after each rising edge, outputs are sampled on the falling edge.
// Backpressure: the bench plays the AXI slave with directed or random ready/valid timing.
module tb_cache_axi_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_inst_call_begin, o_inst_return_ready;
  logic [31:0] i_inst_addr, o_inst_rdata;
  logic        i_data_call_begin, i_data_wen, o_data_return_ready;
  logic [2:0]  i_data_rsize, i_data_wsize;
  logic [31:0] i_data_raddr, i_data_waddr, i_data_wdata, o_data_rdata;
  logic [3:0]  o_arid, o_awid, o_wid, o_arcache, o_awcache, o_wstrb;
  logic [31:0] o_araddr, o_awaddr, o_wdata, i_rdata;
  logic [7:0]  o_arlen, o_awlen;
  logic [2:0]  o_arsize, o_awsize, o_arprot, o_awprot;
  logic [1:0]  o_arburst, o_awburst, o_arlock, o_awlock;
  logic        o_arvalid, i_arready, i_rvalid, o_rready, o_awvalid, i_awready;
  logic        o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [3:0]  i_rid  = 4'd0, i_bid = 4'd0;
  logic [1:0]  i_rresp = 2'd0, i_bresp = 2'd0;
  logic        i_rlast = 1'b1;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .i_inst_call_begin(i_inst_call_begin), .i_inst_addr(i_inst_addr),
    .o_inst_return_ready(o_inst_return_ready), .o_inst_rdata(o_inst_rdata),
    .i_data_call_begin(i_data_call_begin), .i_data_wen(i_data_wen),
    .i_data_rsize(i_data_rsize), .i_data_wsize(i_data_wsize),
    .i_data_raddr(i_data_raddr), .i_data_waddr(i_data_waddr), .i_data_wdata(i_data_wdata),
    .o_data_return_ready(o_data_return_ready), .o_data_rdata(o_data_rdata),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arlock(o_arlock), .o_arcache(o_arcache), .o_arprot(o_arprot),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache), .o_awprot(o_awprot),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  int nvec = 0, nmis = 0, cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic        wen;
    logic [2:0]  rsize, wsize;
    logic [31:0] raddr, waddr, wdata;
  } dreq_t;

  bit          m_valid = 0;
  bit          pend_i = 0, pend_d = 0;
  logic [31:0] pi_addr, cur_iaddr;
  dreq_t       pd, cur;
  // busy: a transaction is in flight; cur_d: it belongs to the data port; cur_w: it is a write.
  // a_done/aw_done/w_done: address or write-data accepted; ret: response received, return this cycle.
  bit          busy = 0, cur_d = 0, cur_w = 0, a_done = 0, aw_done = 0, w_done = 0, ret = 0;
  logic [31:0] e_irdata = '0, e_drdata = '0;

  // Byte lanes touched by an access: n bytes starting at the n-aligned offset.
  function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] a);
    int s, n, av, st;
    s  = (sz > 3'd2) ? 2 : int'(sz);
    n  = 1 << s;
    av = int'(a);
    st = av - (av % n);
    return 4'(((1 << n) - 1) << st);
  endfunction

  task automatic model_step();
    bit clr_i, clr_d;
    cyc_n++;
    clr_i = 0; clr_d = 0;
    if (reset) begin
      m_valid = 1; pend_i = 0; pend_d = 0; busy = 0; ret = 0;
      e_irdata = '0; e_drdata = '0;
      return;
    end
    if (busy) begin
      if (ret) begin
        busy = 0; ret = 0;
        if (cur_d) clr_d = 1; else clr_i = 1;
      end else if (!cur_w) begin
        if (!a_done) a_done = i_arready;
        else if (i_rvalid) begin
          ret = 1;
          if (cur_d) e_drdata = i_rdata; else e_irdata = i_rdata;
        end
      end else begin
        if (!(aw_done && w_done)) begin
          if (i_awready) aw_done = 1;
          if (i_wready)  w_done  = 1;
        end else if (i_bvalid) begin
          ret = 1; e_drdata = '0;
        end
      end
    end else if (pend_d || pend_i) begin
      busy = 1; a_done = 0; aw_done = 0; w_done = 0; ret = 0;
      cur_d = pend_d;
      cur = pd; cur_iaddr = pi_addr;
      cur_w = pend_d && pd.wen;
    end
    if (clr_i) pend_i = 0;
    if (clr_d) pend_d = 0;
    if (i_inst_call_begin && !pend_i) begin pend_i = 1; pi_addr = i_inst_addr; end
    if (i_data_call_begin && !pend_d) begin
      pend_d = 1;
      pd = '{i_data_wen, i_data_rsize, i_data_wsize, i_data_raddr, i_data_waddr, i_data_wdata};
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor + per-cycle comparison ----------------
  int   n_iret = 0, n_dret = 0, dret_cyc = 0, b_cyc = 0, ar_rise = 0, aw_hi = 0, w_hi = 0;
  logic prev_arv = 1'b0;
  logic [31:0] last_irdata, ar_addr_q[$], ar_size_q[$], ar_id_q[$], aw_q[$], ws_q[$], wd_q[$];
  bit   ret_seq[$];

  task automatic compare();
    logic e_arv, e_rr, e_awv, e_wv, e_br;
    if (o_arvalid === 1'b1 && i_arready) begin
      ar_addr_q.push_back(o_araddr); ar_size_q.push_back(32'(o_arsize)); ar_id_q.push_back(32'(o_arid));
    end
    if (o_awvalid === 1'b1 && i_awready) aw_q.push_back(o_awaddr);
    if (o_wvalid === 1'b1 && i_wready) begin ws_q.push_back(32'(o_wstrb)); wd_q.push_back(o_wdata); end
    if (o_bready === 1'b1 && i_bvalid) b_cyc = cyc_n;
    if (o_data_return_ready === 1'b1) begin n_dret++; dret_cyc = cyc_n; ret_seq.push_back(1'b1); end
    if (o_inst_return_ready === 1'b1) begin n_iret++; last_irdata = o_inst_rdata; ret_seq.push_back(1'b0); end
    if (o_arvalid === 1'b1 && prev_arv !== 1'b1) ar_rise = cyc_n;
    prev_arv = o_arvalid;
    if (o_awvalid === 1'b1) aw_hi++;
    if (o_wvalid === 1'b1) w_hi++;
    if (!m_valid) return;

    e_arv = busy && !cur_w && !a_done;
    e_rr  = busy && !cur_w && a_done && !ret;
    e_awv = busy && cur_w && !aw_done;
    e_wv  = busy && cur_w && !w_done;
    e_br  = busy && cur_w && aw_done && w_done && !ret;
    chk("arvalid", o_arvalid, e_arv);
    chk("rready", o_rready, e_rr);
    chk("awvalid", o_awvalid, e_awv);
    chk("wvalid", o_wvalid, e_wv);
    chk("bready", o_bready, e_br);
    chk("inst_return_ready", o_inst_return_ready, busy && ret && !cur_d);
    chk("data_return_ready", o_data_return_ready, busy && ret && cur_d);
    chk("inst_rdata", o_inst_rdata, e_irdata);
    chk("data_rdata", o_data_rdata, e_drdata);
    if (e_arv) begin
      chk("araddr", o_araddr, cur_d ? cur.raddr : cur_iaddr);
      chk("arsize", o_arsize, cur_d ? cur.rsize : 3'd2);
      chk("arid", o_arid, cur_d ? 4'd1 : 4'd0);
    end
    if (e_awv) chk("awaddr", o_awaddr, cur.waddr);
    if (e_wv) begin
      chk("wdata", o_wdata, cur.wdata);
      chk("wstrb", o_wstrb, lanes(cur.wsize, cur.waddr[1:0]));
    end
    chk("const_len", {o_arlen, o_awlen}, 16'h0000);
    chk("const_burst", {o_arburst, o_awburst}, 4'b0101);
    chk("const_ids", {o_awid, o_wid, 3'b000, o_wlast}, {4'd1, 4'd1, 4'b0001});
    chk("const_attr", {o_arlock, o_arcache, o_arprot, o_awlock, o_awcache, o_awprot}, 18'd0);
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    i_inst_call_begin = 0; i_data_call_begin = 0;
    i_arready = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_bvalid = 0;
    i_rdata = '0;
  endtask

  task automatic wait_rets(input int target, input string nm);
    int k = 0;
    while ((n_iret + n_dret) < target && k < 100) begin cyc(); k++; end
    chk(nm, n_iret + n_dret, target);
  endtask

  int base, base_i, base_d;

  initial begin
    reset = 1;
    i_inst_addr = '0; i_data_wen = 0; i_data_rsize = '0; i_data_wsize = '0;
    i_data_raddr = '0; i_data_waddr = '0; i_data_wdata = '0;
    set_idle();
    repeat (3) cyc();
    // Reset state
    chk("rst arvalid", o_arvalid, 0);
    chk("rst awvalid/wvalid", {o_awvalid, o_wvalid}, 0);
    chk("rst rready/bready", {o_rready, o_bready}, 0);
    chk("rst return", {o_inst_return_ready, o_data_return_ready}, 0);
    chk("rst rdata", o_inst_rdata | o_data_rdata, 0);
    chk("rst arburst", o_arburst, 2'b01);
    reset = 0;
    cyc();

    // 1: single fetch, AR waits two cycles
    i_inst_call_begin = 1; i_inst_addr = 32'h0000_1000;
    cyc();
    i_inst_call_begin = 0; i_inst_addr = 32'hDEAD_BEEF;
    cyc();
    chk("t1 arvalid", o_arvalid, 1);
    chk("t1 araddr", o_araddr, 32'h0000_1000);
    chk("t1 arid", o_arid, 4'd0);
    chk("t1 arsize", o_arsize, 3'd2);
    cyc(); cyc();
    i_arready = 1;
    cyc();
    i_arready = 0; i_rvalid = 1; i_rdata = 32'h2402_0001;
    cyc();
    i_rvalid = 0; i_rdata = '0;
    chk("t1 ret pulse", o_inst_return_ready, 1);
    chk("t1 inst_rdata", o_inst_rdata, 32'h2402_0001);
    cyc();
    chk("t1 ret one cycle", o_inst_return_ready, 0);
    chk("t1 rdata held", o_inst_rdata, 32'h2402_0001);

    // 2: simultaneous data read and fetch
    base = n_iret + n_dret;
    ar_addr_q.delete(); ar_size_q.delete(); ar_id_q.delete(); ret_seq.delete();
    i_arready = 1; i_rvalid = 1; i_rdata = 32'h1111_2222;
    i_data_call_begin = 1; i_data_wen = 0; i_data_raddr = 32'h10; i_data_rsize = 3'd1;
    i_inst_call_begin = 1; i_inst_addr = 32'h20;
    cyc();
    i_data_call_begin = 0; i_inst_call_begin = 0;
    wait_rets(base + 2, "t2 both returned");
    repeat (4) cyc();
    chk("t2 ar count", ar_addr_q.size(), 2);
    chk("t2 ret count", ret_seq.size(), 2);
    if (ar_addr_q.size() == 2) begin
      chk("t2 first araddr", ar_addr_q[0], 32'h10);
      chk("t2 first arsize", ar_size_q[0], 1);
      chk("t2 first arid", ar_id_q[0], 1);
      chk("t2 second araddr", ar_addr_q[1], 32'h20);
      chk("t2 second arsize", ar_size_q[1], 2);
    end
    if (ret_seq.size() == 2) chk("t2 data ret first", {ret_seq[0], ret_seq[1]}, 2'b10);
    set_idle();

    // 3: byte write to 0x103
    base = n_iret + n_dret;
    aw_q.delete(); ws_q.delete(); wd_q.delete();
    i_awready = 1; i_wready = 1; i_bvalid = 1;
    i_data_call_begin = 1; i_data_wen = 1; i_data_waddr = 32'h103; i_data_wsize = 3'd0;
    i_data_wdata = 32'hAB00_0000;
    cyc();
    i_data_call_begin = 0;
    wait_rets(base + 1, "t3 write returned");
    cyc();
    chk("t3 aw count", aw_q.size(), 1);
    if (aw_q.size() == 1) chk("t3 awaddr", aw_q[0], 32'h103);
    if (ws_q.size() == 1) begin
      chk("t3 wstrb", ws_q[0], 4'b1000);
      chk("t3 wdata", wd_q[0], 32'hAB00_0000);
    end
    chk("t3 ret after bvalid", dret_cyc - b_cyc, 1);
    set_idle();

    // 4: W accepted before AW
    base = n_iret + n_dret; base_d = n_dret;
    i_wready = 1; i_bvalid = 1;
    i_data_call_begin = 1; i_data_wen = 1; i_data_waddr = 32'h200; i_data_wsize = 3'd2;
    i_data_wdata = 32'h0BAD_CAFE;
    aw_hi = 0; w_hi = 0;
    cyc();
    i_data_call_begin = 0;
    cyc();
    repeat (3) cyc();
    i_awready = 1;
    wait_rets(base + 1, "t4 write returned");
    repeat (5) cyc();
    chk("t4 wvalid cycles", w_hi, 1);
    chk("t4 awvalid cycles", aw_hi, 4);
    chk("t4 single return", n_dret, base_d + 1);
    set_idle();

    // 5: fetch arrives while the write waits in B
    base = n_iret + n_dret; base_i = n_iret;
    i_awready = 1; i_wready = 1;
    i_data_call_begin = 1; i_data_wen = 1; i_data_waddr = 32'h44; i_data_wsize = 3'd2;
    i_data_wdata = 32'h1234_5678;
    cyc();
    i_data_call_begin = 0;
    for (int k = 0; k < 50 && o_bready !== 1'b1; k++) cyc();
    chk("t5 reached B", o_bready, 1);
    i_inst_call_begin = 1; i_inst_addr = 32'h300;
    cyc();
    i_inst_call_begin = 0;
    cyc(); cyc();
    chk("t5 fetch held", o_arvalid, 0);
    i_bvalid = 1; i_arready = 1; i_rvalid = 1; i_rdata = 32'hCAFE_0005;
    wait_rets(base + 2, "t5 both returned");
    chk("t5 AR right after RESP", ar_rise - dret_cyc, 2);
    chk("t5 fetch data", last_irdata, 32'hCAFE_0005);
    chk("t5 fetch once", n_iret, base_i + 1);
    set_idle();
    cyc();

    // 6: reset while waiting in R
    base = n_iret + n_dret;
    i_arready = 1;
    i_inst_call_begin = 1; i_inst_addr = 32'h500;
    cyc();
    i_inst_call_begin = 0;
    for (int k = 0; k < 50 && o_rready !== 1'b1; k++) cyc();
    chk("t6 reached R", o_rready, 1);
    reset = 1;
    cyc();
    reset = 0;
    chk("t6 valids zero", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}, 0);
    chk("t6 rdata zero", o_inst_rdata | o_data_rdata, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t6 stays idle", {o_arvalid, o_inst_return_ready, o_data_return_ready}, 0);
    end
    chk("t6 no return", n_iret + n_dret, base);
    i_rvalid = 1; i_rdata = 32'h600D_F00D;
    i_inst_call_begin = 1; i_inst_addr = 32'h400;
    cyc();
    i_inst_call_begin = 0;
    wait_rets(base + 1, "t6 fetch after reset");
    chk("t6 fetch data", last_irdata, 32'h600D_F00D);
    set_idle();
    cyc();

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_arready = 1'($urandom_range(0, 1));
      i_rvalid  = 1'($urandom_range(0, 1));
      i_awready = 1'($urandom_range(0, 1));
      i_wready  = 1'($urandom_range(0, 1));
      i_bvalid  = 1'($urandom_range(0, 1));
      i_rdata   = $urandom;
      reset     = ($urandom_range(0, 599) == 0);
      i_inst_addr  = $urandom;
      i_data_wen   = 1'($urandom_range(0, 1));
      i_data_rsize = 3'($urandom_range(0, 4));
      i_data_wsize = 3'($urandom_range(0, 4));
      i_data_raddr = $urandom;
      i_data_waddr = $urandom;
      i_data_wdata = $urandom;
      i_inst_call_begin = (!pend_i || (busy && ret && !cur_d)) && ($urandom_range(0, 3) == 0);
      i_data_call_begin = (!pend_d || (busy && ret && cur_d)) && ($urandom_range(0, 3) == 0);
      cyc();
    end
    reset = 0;
    set_idle();
    i_arready = 1; i_rvalid = 1; i_awready = 1; i_wready = 1; i_bvalid = 1;
    repeat (40) cyc();
    chk("drain idle", {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
